led_bcm_scanner: RTL

Scan/sequencing stage for the 64×64 HUB75-style panel. It walks rows and binary-coded-modulation (BCM) bit planes and drives `x`, `y`, `frame` and `subframe` into the downstream `painter24`. It takes back the painter's registered `rgb24` one cycle later, slices out the current plane bit per channel, and shifts, latches and displays it on the panel pins. It sits between the top-level panel wiring and the painter, and owns all panel timing.

---
 rtl/led_bcm_scanner_if.sv | 18 +
 rtl/led_bcm_scanner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_bcm_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : led_bcm_scanner_if
// Brief    : Scanner <-> painter24 bus: pixel coordinates out, registered
//            24-bit colour back one clock later.
// Revision : 1.0 - initial release
// ============================================================================
interface led_bcm_scanner_if;
   logic [9:0]  frame;
   logic [7:0]  subframe;
   logic [5:0]  x;
   logic [5:0]  y;
   logic [23:0] rgb24;

   modport master (output frame, subframe, x, y, input rgb24);
   modport slave  (input frame, subframe, x, y, output rgb24);
endinterface
`default_nettype wire

// File: rtl/led_bcm_scanner.sv
`default_nettype none
// ============================================================================
// Module   : led_bcm_scanner
// Brief    : HUB75 1/32-scan row and BCM bit-plane sequencer; drives painter24
//            coordinates and the panel shift/latch/OE pins.
//            Optional macro LED_BCM_MSB_FIRST_EN runs each row's planes MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module led_bcm_scanner #(
   parameter int WIDTH = 64,
   parameter int ROWS  = 32,
   parameter int BITS  = 8,
   parameter int DELAY = 1
) (
   input  wire logic          clk,
   input  wire logic          resetn,
   led_bcm_scanner_if.master  painter,
   output logic [2:0]         rgb_top,
   output logic [2:0]         rgb_bot,
   output logic [4:0]         addr,
   output logic               sclk,
   output logic               latch,
   output logic               oe_n
);

   localparam int         c_DCW      = $clog2((DELAY << (BITS - 1)) + 1);
   localparam logic [5:0] c_COL_LAST = 6'(WIDTH - 1);
   localparam logic [4:0] c_ROW_LAST = 5'(ROWS - 1);
   localparam logic [5:0] c_ROWS     = 6'(ROWS);
   localparam logic [2:0] c_BOFF     = 3'(8 - BITS);
`ifdef LED_BCM_MSB_FIRST_EN
   localparam logic [2:0] c_P_FIRST  = 3'(BITS - 1);
   localparam logic [2:0] c_P_LAST   = 3'd0;
`else
   localparam logic [2:0] c_P_FIRST  = 3'd0;
   localparam logic [2:0] c_P_LAST   = 3'(BITS - 1);
`endif

   typedef enum logic [1:0] {
      S_SHIFT   = 2'd0,
      S_BLANK   = 2'd1,
      S_LATCH   = 2'd2,
      S_DISPLAY = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_ph;
   logic [5:0]       r_col;
   logic [4:0]       r_row;
   logic [2:0]       r_plane;
   logic [9:0]       r_frame;
   logic [c_DCW-1:0] r_dcnt;
   logic [5:0]       r_x;
   logic [5:0]       r_y;
   logic [2:0]       r_top_pix;

   logic [2:0]       w_bsel;
   logic [2:0]       w_pix;
   logic [2:0]       w_plane_nxt;
   logic [4:0]       w_row_nxt;
   logic [4:0]       w_row_adv;
   logic             w_col_last;
   logic             w_plane_last;
   logic             w_row_last;
   logic             w_disp_done;

   assign painter.frame    = r_frame;
   assign painter.subframe = {5'd0, r_plane};
   assign painter.x        = r_x;
   assign painter.y        = r_y;

   always_comb begin
      w_bsel       = c_BOFF + r_plane;
      // {B,G,R} bits of the current plane out of the painter word
      w_pix        = {painter.rgb24[{2'd2, w_bsel}],
                      painter.rgb24[{2'd1, w_bsel}],
                      painter.rgb24[{2'd0, w_bsel}]};
      w_col_last   = (r_col == c_COL_LAST);
      w_plane_last = (r_plane == c_P_LAST);
      w_row_last   = (r_row == c_ROW_LAST);
      w_disp_done  = (r_dcnt == '0);
      w_row_nxt    = w_row_last ? 5'd0 : r_row + 5'd1;
      w_row_adv    = w_plane_last ? w_row_nxt : r_row;
`ifdef LED_BCM_MSB_FIRST_EN
      w_plane_nxt  = w_plane_last ? c_P_FIRST : r_plane - 3'd1;
`else
      w_plane_nxt  = w_plane_last ? c_P_FIRST : r_plane + 3'd1;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_SHIFT:   if (r_ph == 2'd3 && w_col_last) w_state_nxt = S_BLANK;
         S_BLANK:   w_state_nxt = S_LATCH;
         S_LATCH:   w_state_nxt = S_DISPLAY;
         S_DISPLAY: if (w_disp_done) w_state_nxt = S_SHIFT;
         default:   w_state_nxt = S_SHIFT;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_SHIFT;
      else         r_state <= w_state_nxt;
   end

   // Each branch performs the action of the phase/state being left on this edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ph      <= 2'd0;
         r_col     <= 6'd0;
         r_row     <= 5'd0;
         r_plane   <= c_P_FIRST;
         r_frame   <= 10'd0;
         r_dcnt    <= '0;
         r_x       <= 6'd0;
         r_y       <= 6'd0;
         r_top_pix <= 3'd0;
         rgb_top   <= 3'd0;
         rgb_bot   <= 3'd0;
         addr      <= 5'd0;
         sclk      <= 1'b0;
         latch     <= 1'b0;
         oe_n      <= 1'b1;
      end else begin
         latch <= 1'b0;
         case (r_state)
            S_SHIFT: begin
               r_ph <= r_ph + 2'd1;
               case (r_ph)
                  2'd0: r_y <= {1'b0, r_row} + c_ROWS;
                  2'd1: r_top_pix <= w_pix;
                  2'd2: begin
                     rgb_top <= r_top_pix;
                     rgb_bot <= w_pix;
                     sclk    <= 1'b0;
                  end
                  default: begin
                     sclk <= 1'b1;
                     if (!w_col_last) begin
                        r_col <= r_col + 6'd1;
                        r_x   <= r_col + 6'd1;
                        r_y   <= {1'b0, r_row};
                     end
                  end
               endcase
            end
            S_BLANK: begin
               sclk  <= 1'b0;
               latch <= 1'b1;
               addr  <= r_row;
            end
            S_LATCH: begin
               oe_n   <= 1'b0;
               r_dcnt <= (c_DCW'(DELAY) << r_plane) - c_DCW'(1);
            end
            default: begin
               if (w_disp_done) begin
                  oe_n    <= 1'b1;
                  r_col   <= 6'd0;
                  r_x     <= 6'd0;
                  r_y     <= {1'b0, w_row_adv};
                  r_plane <= w_plane_nxt;
                  if (w_plane_last) begin
                     r_row <= w_row_nxt;
                     if (w_row_last) r_frame <= r_frame + 10'd1;
                  end
               end else begin
                  r_dcnt <= r_dcnt - c_DCW'(1);
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire
